// File: rtl/branch_target_fetch_pc.sv
// branch_target_fetch_pc
//   Program-counter sequencer. Normally advances the PC by INC per advance
//   period. On a branch request it enables the branch address register onto
//   the shared bus (bus_cs low), lets the bus settle, samples the address and
//   loads it into the PC.
//
//   Ports
//     Clock        in   system clock, rising edge
//     Reset        in   asynchronous, active-high reset
//     ClockEnable  in   clock enable
//     Tick         in   clock-divider tick (advance = ClockEnable & Tick)
//     branch_req   in   level request to redirect the PC
//     stall        in   freeze sequential PC advance
//     bus_in       in   shared bus from the branch address register
//     bus_cs       out  register chip-select, 0 = register drives bus
//     pc           out  current program counter
//     pc_valid     out  PC valid for fetch
//     branch_busy  out  redirect in progress
//     branch_done  out  one advance-period pulse when the redirect lands
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | bus released, PC advancing (or stalled)
//   SELECT  | bus_cs low, counting down settle periods
//   CAPTURE | sample bus_in while still selected, then release the bus
//   LOAD    | copy captured target into the PC, pulse branch_done
module branch_target_fetch_pc #(
    parameter int unsigned ADDR_BITS     = 32,
    parameter int unsigned INC           = 4,
    parameter int unsigned RESET_PC      = 0,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 branch_req,
    input  logic                 stall,
    input  logic [ADDR_BITS-1:0] bus_in,
    output logic                 bus_cs,
    output logic [ADDR_BITS-1:0] pc,
    output logic                 pc_valid,
    output logic                 branch_busy,
    output logic                 branch_done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_CAPTURE,
        ST_LOAD
    } state_t;

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [ADDR_BITS-1:0]   pc_q,     pc_d;
    logic [ADDR_BITS-1:0]   target_q, target_d;
    logic                   cs_q,     cs_d;
    logic                   valid_q,  valid_d;
    logic                   busy_q,   busy_d;
    logic                   done_q,   done_d;

    logic advance;
    assign advance = ClockEnable & Tick;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pc_q     <= ADDR_BITS'(RESET_PC);
            target_q <= '0;
            cs_q     <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            cs_q     <= cs_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_d     = pc_q;
        target_d = target_q;
        cs_d     = cs_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        done_d   = done_q;

        if (advance) begin
            valid_d = 1'b1;
            // done is a single-period pulse; only LOAD re-asserts it
            done_d  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cs_d = 1'b1;
                    if (branch_req) begin
                        state_d = ST_SELECT;
                        cs_d    = 1'b0;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    end else if (!stall) begin
                        pc_d = pc_q + ADDR_BITS'(INC);
                    end
                end
                ST_SELECT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // bus_cs is still low on this edge, so bus_in is driven
                    target_d = bus_in;
                    cs_d     = 1'b1;
                    state_d  = ST_LOAD;
                end
                ST_LOAD: begin
                    pc_d    = target_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cs_d    = 1'b1;
                end
            endcase
        end
    end

    assign bus_cs      = cs_q;
    assign pc          = pc_q;
    assign pc_valid    = valid_q;
    assign branch_busy = busy_q;
    assign branch_done = done_q;

endmodule

// File: tb/tb_branch_target_fetch_pc.sv
// Two instances share stimulus: SETTLE_CYCLES=1 (u_s1) and SETTLE_CYCLES=3
// (u_s3). Each register's bus is driven with the target only while its cs is
// low and with random junk otherwise.
module tb_branch_target_fetch_pc;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ClockEnable;
    logic        Tick;
    logic        branch_req;
    logic        stall;
    logic [31:0] tgt_val;
    logic [31:0] junk;

    logic [31:0] bus0, bus1, pc0, pc1;
    logic        cs0, cs1, valid0, valid1, busy0, busy1, done0, done1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 Clock = ~Clock;

    assign bus0 = cs0 ? junk : tgt_val;
    assign bus1 = cs1 ? junk : tgt_val;

    branch_target_fetch_pc #(.ADDR_BITS(32), .INC(4), .RESET_PC(0), .SETTLE_CYCLES(1)) u_s1 (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .branch_req(branch_req), .stall(stall), .bus_in(bus0), .bus_cs(cs0),
        .pc(pc0), .pc_valid(valid0), .branch_busy(busy0), .branch_done(done0)
    );

    branch_target_fetch_pc #(.ADDR_BITS(32), .INC(4), .RESET_PC(0), .SETTLE_CYCLES(3)) u_s3 (
        .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
        .branch_req(branch_req), .stall(stall), .bus_in(bus1), .bus_cs(cs1),
        .pc(pc1), .pc_valid(valid1), .branch_busy(busy1), .branch_done(done1)
    );

    // Reference model: a fetch is a count of advances since the request.
    // Advances 1..S keep the bus selected, advance S+1 samples it and
    // releases cs, advance S+2 lands the target in the PC.
    int          s_cyc[2] = '{1, 3};
    logic [31:0] m_pc[2];
    logic [31:0] m_tgt[2];
    bit          m_busy[2];
    bit          m_done[2];
    bit          m_valid[2];
    int          m_pos[2];

    function automatic bit m_cs(input int i);
        return !(m_busy[i] && (m_pos[i] <= s_cyc[i]));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]    = 32'd0;
            m_tgt[i]   = 32'd0;
            m_busy[i]  = 1'b0;
            m_done[i]  = 1'b0;
            m_valid[i] = 1'b0;
            m_pos[i]   = 0;
        end
    endtask

    task automatic model_adv(input bit req, input bit st);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] bus;
            bus        = m_cs(i) ? junk : tgt_val;
            m_valid[i] = 1'b1;
            m_done[i]  = 1'b0;
            if (!m_busy[i]) begin
                if (req) begin
                    m_busy[i] = 1'b1;
                    m_pos[i]  = 0;
                end else if (!st) begin
                    m_pc[i] = m_pc[i] + 32'd4;
                end
            end else begin
                m_pos[i]++;
                if (m_pos[i] == s_cyc[i] + 1) m_tgt[i] = bus;
                if (m_pos[i] == s_cyc[i] + 2) begin
                    m_pc[i]   = m_tgt[i];
                    m_done[i] = 1'b1;
                    m_busy[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s1_pc",    pc0,           m_pc[0]);
        chk("s1_cs",    32'(cs0),      32'(m_cs(0)));
        chk("s1_valid", 32'(valid0),   32'(m_valid[0]));
        chk("s1_busy",  32'(busy0),    32'(m_busy[0]));
        chk("s1_done",  32'(done0),    32'(m_done[0]));
        chk("s3_pc",    pc1,           m_pc[1]);
        chk("s3_cs",    32'(cs1),      32'(m_cs(1)));
        chk("s3_valid", 32'(valid1),   32'(m_valid[1]));
        chk("s3_busy",  32'(busy1),    32'(m_busy[1]));
        chk("s3_done",  32'(done1),    32'(m_done[1]));
    endtask

    // Inputs change 1ns after a rising edge; model steps before the next edge.
    task automatic step(input bit ce, input bit tk, input bit req, input bit st);
        ClockEnable = ce;
        Tick        = tk;
        branch_req  = req;
        stall       = st;
        junk        = $urandom;
        @(negedge Clock);
        if (ce && tk) model_adv(req, st);
        @(posedge Clock);
        #1;
        check_all();
    endtask

    // Called 1ns after a rising edge; checks the asynchronous effect at once.
    task automatic do_reset();
        ClockEnable = 1'b0;
        Tick        = 1'b0;
        branch_req  = 1'b0;
        stall       = 1'b0;
        Reset       = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
    endtask

    // Start a fetch, then wait with stall high so both PCs settle on target.
    task automatic fetch_and_hold(input logic [31:0] t);
        tgt_val = t;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        Reset       = 1'b1;
        ClockEnable = 1'b0;
        Tick        = 1'b0;
        branch_req  = 1'b0;
        stall       = 1'b0;
        tgt_val     = 32'd0;
        junk        = $urandom;
        #2;
        do_reset();

        // sequential advance
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("seq_pc12", pc0, 32'd12);

        // gating: ClockEnable without Tick and vice versa
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("gate_pc", pc0, 32'd12);

        // redirect to 0x100, then to 0x2040 with the S=1 latency
        fetch_and_hold(32'h0000_0100);
        chk("pc_100", pc1, 32'h0000_0100);
        tgt_val = 32'h0000_2040;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pc_2040", pc0, 32'h0000_2040);
        chk("done_2040", 32'(done0), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pc_2044", pc0, 32'h0000_2044);
        for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 1'b0, 1'b1);

        // request and stall together; toggling stall and dropping req while busy
        tgt_val = 32'h0000_5550;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        for (int n = 0; n < 6; n++) step(1'b1, 1'b1, 1'b0, 1'(n % 2));

        // Tick every third clock with S=3: five advances per fetch
        tgt_val = 32'h3000_0000;
        for (int c = 0; c < 18; c++) step(1'b1, 1'(c % 3 == 2), 1'(c == 2), 1'b0);
        chk("tick_pc", pc1, 32'h3000_0000);
        chk("tick_done", 32'(done1), 32'd1);

        // reset in the middle of a fetch
        tgt_val = 32'h0000_7770;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_cs", 32'(cs1), 32'd0);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pc", pc1, 32'd4);

        // wrap and all-ones target
        fetch_and_hold(32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("wrap_pc", pc0, 32'h0000_0000);
        fetch_and_hold(32'hFFFF_FFFF);
        chk("ones_pc", pc1, 32'hFFFF_FFFF);

        // random traffic, including req held through LOAD
        for (int n = 0; n < 400; n++) begin
            tgt_val = $urandom;
            step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
